// File: rtl/serial_chunk_adder_if.sv
// Bundle of request/result signals for serial_chunk_adder.
//
// Handshake: start is a one-cycle request. It is taken on a rising edge
// only while busy is low; a, b, c and sub are sampled on that edge alone.
// busy stays high until the edge that raises done. done is a single-cycle
// pulse, and s/car/ovf are valid from that edge until the next completion.
// A start held high during the done cycle is taken immediately.
interface serial_chunk_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             car;
    logic             ovf;
    logic             busy;
    logic             done;
    logic             dbg_state;

    modport master (
        output start, a, b, c, sub,
        input  s, car, ovf, busy, done, dbg_state
    );

    modport slave (
        input  start, a, b, c, sub,
        output s, car, ovf, busy, done, dbg_state
    );
endinterface

// File: rtl/serial_chunk_adder.sv
// Bit-serial (chunk-serial) adder/subtractor: adds CHUNK bits per clock,
// LSB slice first, and publishes the full result on completion only.
// WIDTH must be an integer multiple of CHUNK, with CHUNK >= 1.
module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_chunk_adder_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] s_q;
    logic             car_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    int               base;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sl_sum;
    logic [WIDTH-1:0] full_sum;
    logic             msb_cin;

    // Slice adder for the current chunk; full_sum is the accumulated sum
    // with the current slice merged in, so it is complete on the last slice.
    // The carry into the MSB is recovered from sum = a ^ b ^ carry_in.
    always_comb begin
        base     = int'(cnt) * CHUNK;
        a_sl     = opa[base +: CHUNK];
        b_sl     = opb[base +: CHUNK];
        sl_sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, cy};
        full_sum = acc;
        full_sum[base +: CHUNK] = sl_sum[CHUNK-1:0];
        msb_cin  = opa[WIDTH-1] ^ opb[WIDTH-1] ^ full_sum[WIDTH-1];
    end

    // Control FSM and datapath registers; results load only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cy     <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            car_q  <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa    <= bus.a;
                        // Subtraction is a + ~b + 1; c is ignored then.
                        opb    <= bus.sub ? ~bus.b : bus.b;
                        cy     <= bus.sub ? 1'b1 : bus.c;
                        cnt    <= '0;
                        acc    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= full_sum;
                    cy  <= sl_sum[CHUNK];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        s_q    <= full_sum;
                        car_q  <= sl_sum[CHUNK];
                        ovf_q  <= msb_cin ^ sl_sum[CHUNK];
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s         = s_q;
    assign bus.car       = car_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state;
endmodule
